// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and helpers for the write-back arbiter: default widths,
// write-port source encoding and the destination one-hot decoder.
package reg_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREG_MAX   = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } src_e;

    function automatic logic [NREG_MAX-1:0] onehot(input logic [ADDR_W_DEF-1:0] a);
        logic [NREG_MAX-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Pipeline, multi-cycle handshake and register-file write-port bundle.
interface reg_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NREG = 2 ** ADDR_W;

    logic              pipe_we_i;
    logic              pipe_memtoreg_i;
    logic [ADDR_W-1:0] pipe_addr_i;
    logic [DATA_W-1:0] pipe_alu_i;
    logic [DATA_W-1:0] pipe_mem_i;
    logic              mc_valid_i;
    logic              mc_ready_o;
    logic [ADDR_W-1:0] mc_addr_i;
    logic [DATA_W-1:0] mc_data_i;
    logic              RegWrite_o;
    logic [ADDR_W-1:0] RDaddr_o;
    logic [DATA_W-1:0] RDdata_o;
    logic [NREG-1:0]   pend_mask_o;
    logic              stall_o;
    logic              busy_o;

    modport slave (
        input  pipe_we_i, pipe_memtoreg_i, pipe_addr_i, pipe_alu_i, pipe_mem_i,
        input  mc_valid_i, mc_addr_i, mc_data_i,
        output mc_ready_o, RegWrite_o, RDaddr_o, RDdata_o, pend_mask_o, stall_o, busy_o
    );

    modport master (
        output pipe_we_i, pipe_memtoreg_i, pipe_addr_i, pipe_alu_i, pipe_mem_i,
        output mc_valid_i, mc_addr_i, mc_data_i,
        input  mc_ready_o, RegWrite_o, RDaddr_o, RDdata_o, pend_mask_o, stall_o, busy_o
    );

endinterface

// File: rtl/reg_wb_arbiter_wb_fifo.sv
// DEPTH-entry FIFO for multi-cycle results; exposes per-entry address/valid
// taps so the top can build the pending-destination mask.
module reg_wb_arbiter_wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic [ADDR_W-1:0]             head_addr_o,
    output logic [DATA_W-1:0]             head_data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [DEPTH-1:0]              ent_vld_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 count_q, count_d;
    logic [DEPTH-1:0]              vld_q, vld_d;
    logic [DEPTH-1:0][ADDR_W-1:0]  mem_addr_q;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (pop_i) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (push_i) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by vld_q.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_addr_q[wr_ptr_q] <= addr_i;
            mem_data_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_addr_o = mem_addr_q[rd_ptr_q];
    assign head_data_o = mem_data_q[rd_ptr_q];
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign ent_vld_o   = vld_q;
    assign ent_addr_o  = mem_addr_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: pipe results win the register write port, buffered
// multi-cycle results drain into free cycles, starvation raises stall_o.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    reg_wb_arbiter_if.slave   bus
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int SW   = $clog2(STARVE + 1);

    logic                          fifo_full, fifo_empty, push, pop, pipe_win, mc_ready;
    logic [ADDR_W-1:0]             head_addr;
    logic [DATA_W-1:0]             head_data;
    logic [DEPTH-1:0]              ent_vld;
    logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr;
    src_e                          src;

    logic              we_q, we_d, stall_q, stall_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [NREG-1:0]   pend_mask;
    logic [NREG_MAX-1:0] dec;

    reg_wb_arbiter_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_wb_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .pop_i       (pop),
        .addr_i      (bus.mc_addr_i),
        .data_i      (bus.mc_data_i),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .ent_vld_o   (ent_vld),
        .ent_addr_o  (ent_addr)
    );

    assign pipe_win = bus.pipe_we_i && (bus.pipe_addr_i != '0);
    assign mc_ready = !fifo_full;
    // Results for r0 complete the handshake but are never buffered.
    assign push     = bus.mc_valid_i && mc_ready && (bus.mc_addr_i != '0);
    assign pop      = (src == SRC_FIFO);

    always_comb begin
        src      = SRC_NONE;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        if (pipe_win) begin
            src    = SRC_PIPE;
            we_d   = 1'b1;
            addr_d = bus.pipe_addr_i;
            data_d = bus.pipe_memtoreg_i ? bus.pipe_mem_i : bus.pipe_alu_i;
        end else if (!fifo_empty) begin
            src    = SRC_FIFO;
            we_d   = 1'b1;
            addr_d = head_addr;
            data_d = head_data;
        end
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (pipe_win && (starve_q != SW'(STARVE))) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (starve_d == SW'(STARVE));
    end

    always_comb begin
        pend_mask = '0;
        dec       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dec = onehot(ADDR_W_DEF'(ent_addr[i]));
            if (ent_vld[i]) pend_mask = pend_mask | dec[NREG-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.mc_ready_o  = mc_ready;
    assign bus.RegWrite_o  = we_q;
    assign bus.RDaddr_o    = addr_q;
    assign bus.RDdata_o    = data_q;
    assign bus.pend_mask_o = pend_mask;
    assign bus.stall_o     = stall_q;
    assign bus.busy_o      = !fifo_empty;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed and randomized bench for reg_wb_arbiter against a queue-based model.
module tb_reg_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic clk   = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    int errors = 0;
    int checks = 0;

    // Reference state: queued results, starvation count, expected write port.
    ent_t              q[$];
    int                starve;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) m[q[i].a] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        starve = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we"},    64'(bus.RegWrite_o),  64'(m_we));
        chk({tag, ".addr"},  64'(bus.RDaddr_o),    64'(m_addr));
        chk({tag, ".data"},  64'(bus.RDdata_o),    64'(m_data));
        chk({tag, ".stall"}, 64'(bus.stall_o),     64'(starve == STARVE));
        chk({tag, ".busy"},  64'(bus.busy_o),      64'(q.size() != 0));
        chk({tag, ".ready"}, 64'(bus.mc_ready_o),  64'(q.size() < DEPTH));
        chk({tag, ".mask"},  64'(bus.pend_mask_o), 64'(exp_mask()));
    endtask

    task automatic set_in(input logic pwe, input logic mtr, input logic [ADDR_W-1:0] pa,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                          input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
        bus.pipe_we_i       = pwe;
        bus.pipe_memtoreg_i = mtr;
        bus.pipe_addr_i     = pa;
        bus.pipe_alu_i      = alu;
        bus.pipe_mem_i      = mem;
        bus.mc_valid_i      = mv;
        bus.mc_addr_i       = ma;
        bus.mc_data_i       = md;
    endtask

    // One clock: apply the write-port rules to the current inputs, then check.
    task automatic cycle(input string tag, output bit acc);
        bit   win, ready, nonempty, popped;
        ent_t e;
        ready    = (q.size() < DEPTH);
        chk({tag, ".ready_pre"}, 64'(bus.mc_ready_o), 64'(ready));
        win      = bus.pipe_we_i && (bus.pipe_addr_i != 0);
        nonempty = (q.size() != 0);
        popped   = 1'b0;
        m_we     = 1'b0;
        if (win) begin
            m_we   = 1'b1;
            m_addr = bus.pipe_addr_i;
            m_data = bus.pipe_memtoreg_i ? bus.pipe_mem_i : bus.pipe_alu_i;
        end else if (nonempty) begin
            e      = q.pop_front();
            m_we   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
            popped = 1'b1;
        end
        acc = bus.mc_valid_i && ready;
        if (acc && bus.mc_addr_i != 0) q.push_back('{a: bus.mc_addr_i, d: bus.mc_data_i});
        if (popped || !nonempty) starve = 0;
        else if (win && starve < STARVE) starve++;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        bit acc, pend_v, pwe;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;

        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_i = 1'b0;
        #1 check_all("reset");
        @(posedge clk);
        @(negedge clk) rst_i = 1'b1;

        // Pipe write, ALU then load data.
        set_in(1, 0, 5, 32'h1234, 32'h0, 0, 0, 0);
        cycle("pipe_alu", acc);
        chk("pipe_alu.addr_c", 64'(bus.RDaddr_o), 64'd5);
        chk("pipe_alu.data_c", 64'(bus.RDdata_o), 64'h1234);
        set_in(1, 1, 5, 32'h1111, 32'hBEEF, 0, 0, 0);
        cycle("pipe_mem", acc);
        chk("pipe_mem.data_c", 64'(bus.RDdata_o), 64'hBEEF);

        // Multi-cycle result with an idle pipe: mask first, write a cycle later.
        set_in(0, 0, 0, 0, 0, 1, 7, 32'hCAFE);
        cycle("mc_push", acc);
        chk("mc_push.mask7", 64'(bus.pend_mask_o[7]), 64'd1);
        chk("mc_push.we_c", 64'(bus.RegWrite_o), 64'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("mc_pop", acc);
        chk("mc_pop.addr_c", 64'(bus.RDaddr_o), 64'd7);
        chk("mc_pop.data_c", 64'(bus.RDdata_o), 64'hCAFE);
        chk("mc_pop.mask_c", 64'(bus.pend_mask_o), 64'd0);

        // Fill under continuous pipe writes until starvation stalls.
        set_in(1, 0, 10, 32'hA0, 0, 1, 3, 32'h33);
        cycle("starve0", acc);
        set_in(1, 0, 11, 32'hA1, 0, 1, 4, 32'h44);
        cycle("starve1", acc);
        chk("starve1.full", 64'(bus.mc_ready_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 5'(12 + k), 32'(32'hB0 + k), 0, 0, 0, 0);
            cycle("starve_n", acc);
        end
        chk("starve.stall_c", 64'(bus.stall_o), 64'd1);
        set_in(1, 0, 15, 32'hB5, 0, 0, 0, 0);
        cycle("starve_ovr", acc);
        chk("starve_ovr.addr_c", 64'(bus.RDaddr_o), 64'd15);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("drain_r3", acc);
        chk("drain_r3.addr_c", 64'(bus.RDaddr_o), 64'd3);
        chk("drain_r3.stall_c", 64'(bus.stall_o), 64'd0);
        cycle("drain_r4", acc);
        chk("drain_r4.data_c", 64'(bus.RDdata_o), 64'h44);

        // r0 targets: dropped by both sources, handshake still completes.
        set_in(1, 0, 0, 32'hDEAD, 0, 1, 0, 32'h77);
        cycle("r0", acc);
        chk("r0.we_c", 64'(bus.RegWrite_o), 64'd0);
        chk("r0.busy_c", 64'(bus.busy_o), 64'd0);

        // Push and pop together at count 1 across pointer wrap.
        set_in(0, 0, 0, 0, 0, 1, 1, 32'hA1);
        cycle("pp_seed", acc);
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 0, 0, 0, 1, 5'(2 + k), 32'(32'hB0 + k));
            cycle("pp", acc);
            chk("pp.busy_c", 64'(bus.busy_o), 64'd1);
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("pp_drain", acc);
        chk("pp_drain.addr_c", 64'(bus.RDaddr_o), 64'd6);

        // Asynchronous reset with two entries queued.
        set_in(1, 0, 20, 32'h20, 0, 1, 8, 32'h88);
        cycle("ar_fill0", acc);
        set_in(1, 0, 21, 32'h21, 0, 1, 9, 32'h99);
        cycle("ar_fill1", acc);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #3 rst_i = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        chk("arst.we_c", 64'(bus.RegWrite_o), 64'd0);
        rst_i = 1'b1;
        cycle("arst_rel", acc);

        // Randomized traffic; producer holds its result until accepted.
        pend_v = 1'b0;
        pa     = '0;
        pd     = '0;
        for (int n = 0; n < 600; n++) begin
            if (!pend_v && $urandom_range(0, 1) == 1) begin
                pend_v = 1'b1;
                pa     = 5'($urandom_range(0, 31));
                pd     = $urandom;
            end
            pwe = (starve == STARVE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            set_in(pwe, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                   pend_v, pa, pd);
            cycle("rnd", acc);
            if (acc) pend_v = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-back arbiter and the single writer of the register file write port (`RDaddr`/`RDdata`/`RegWrite`). It merges the in-order MEM/WB pipeline result with out-of-order results from a multi-cycle unit (mult/div) arriving over a valid/ready handshake. Multi-cycle results are buffered in a small FIFO and drained into free write-port cycles. Pending destinations are exported so the hazard unit can stall dependent instructions.

## Interface
- `DATA_W`, 32, data width
- `ADDR_W`, 5, register address width
- `DEPTH`, 2, multi-cycle result FIFO entries (power of 2, ≥2)
- `STARVE`, 4, consecutive blocked cycles before `stall_o` is raised
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: asynchronous, active-low reset
- `pipe_we_i` in 1: MEM/WB RegWrite
- `pipe_memtoreg_i` in 1: 1 selects `pipe_mem_i`, 0 selects `pipe_alu_i`
- `pipe_addr_i` in ADDR_W: pipeline destination
- `pipe_alu_i` in DATA_W: ALU result
- `pipe_mem_i` in DATA_W: load data
- `mc_valid_i` in 1: multi-cycle result valid
- `mc_ready_o` out 1: FIFO can accept
- `mc_addr_i` in ADDR_W: multi-cycle destination
- `mc_data_i` in DATA_W: multi-cycle result
- `RegWrite_o` out 1: write strobe to register file
- `RDaddr_o` out ADDR_W: write address
- `RDdata_o` out DATA_W: write data
- `pend_mask_o` out 2^ADDR_W: bit n set while a FIFO entry targets register n
- `stall_o` out 1: request to the hazard unit to bubble the pipeline write
- `busy_o` out 1: FIFO non-empty

## Operation
- Per cycle, the write-port source is chosen as follows:
  - The source is the pipe if `pipe_we_i && pipe_addr_i!=0`.
  - Otherwise it is the FIFO head if the FIFO is non-empty. The head is popped.
  - Otherwise there is no write.
- The chosen address and data are registered into `RDaddr_o`/`RDdata_o`, and `RegWrite_o` is set to 1. With no write, `RegWrite_o` is 0 and address and data hold their previous values.
- Pipe writes to r0 are dropped. `RegWrite_o` never asserts with `RDaddr_o==0`.
- Multi-cycle accept is `mc_valid_i && mc_ready_o`.
  - An accepted entry with `mc_addr_i==0` is consumed and discarded. It is not enqueued.
  - `mc_ready_o = (count < DEPTH)`, combinational from count only. It does not depend on a same-cycle pop.
- Push and pop in the same cycle leave count unchanged. FIFO order is preserved, and pointers wrap modulo DEPTH.
- `pend_mask_o` is the OR of the one-hot decodes of the addresses of valid entries. It updates the cycle after a push or pop.
- Starvation counter:
  - It increments each cycle the FIFO is non-empty and a pipe write wins.
  - It clears on any pop, or when the FIFO is empty.
  - It saturates at `STARVE`.
- `stall_o` is registered, set while the counter equals `STARVE`.
  - The hazard unit must then present `pipe_we_i=0` the next cycle.
  - If the pipe still writes, the pipe wins. The FIFO keeps waiting and no entry is lost.
- Ordering between a pipe write and a FIFO entry to the same register is not resolved here. The hazard unit uses `pend_mask_o` to prevent it.

## Timing
- Reset values:
  - `RegWrite_o`=0, `RDaddr_o`=0, `RDdata_o`=0
  - `pend_mask_o`=0, `stall_o`=0, `busy_o`=0
  - FIFO empty, so `mc_ready_o`=1
  - starvation counter 0
- Pipe latency is 1 cycle: inputs at edge N appear on the write port after edge N+1. The register file's write-through bypass covers the read in that same cycle.
- Multi-cycle latency is a minimum of 2 cycles: push at edge N, pop selected in cycle N+1, write visible after edge N+2.
- Full FIFO: `mc_ready_o`=0. The producer must hold `mc_valid_i`/`mc_addr_i`/`mc_data_i` stable until accepted.
- Reset asserted mid-operation clears the FIFO, counter and outputs immediately (asynchronous). Buffered results are lost.
- Throughput is one register write per cycle.

## Structure
- A shared package holds `DATA_W`/`ADDR_W` defaults, the one-hot decode function, and the source-select enum (NONE, PIPE, FIFO).
- Sub-module `wb_fifo`: DEPTH-entry synchronous FIFO with push/pop, count, full/empty flags, and per-entry address/valid taps feeding `pend_mask_o`.
- Top level contains the select logic, starvation counter and output registers.

## Test plan
- Reset release, then pipe write r5 with ALU=0x1234 and memtoreg=0 → the next cycle shows `RegWrite_o`=1, `RDaddr_o`=5, `RDdata_o`=0x1234. With memtoreg=1 and mem=0xBEEF, `RDdata_o`=0xBEEF.
- Multi-cycle push of r7=0xCAFE with no pipe activity → `pend_mask_o[7]`=1 one cycle later. The write of r7 appears 2 cycles after accept, and the mask bit then clears.
- Push r3 then r4 while the pipe writes every cycle:
  - The FIFO fills and `mc_ready_o`=0.
  - After 4 blocked cycles `stall_o`=1.
  - Drop `pipe_we_i` → r3, then r4, are written in order and `stall_o` returns to 0.
- Push to r0 and pipe write to r0 → `RegWrite_o` stays 0, the FIFO stays empty, and the handshake still completes.
- Simultaneous push and pop at count=1 → count stays 1, with order and data intact across pointer wrap.
- Assert `rst_i`=0 asynchronously with 2 entries queued → all outputs are 0 immediately, and `mc_ready_o`=1 after release.
